// File: rtl/lcd_write_controller.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_controller
// Brief    : HD44780 4-bit write controller: power-on init, then byte writes.
// Revision : 1.0
// ============================================================================
module lcd_write_controller #(
  parameter int P_T_SETUP   = 2,
  parameter int P_T_PULSE   = 12,
  parameter int P_T_HOLD    = 1,
  parameter int P_T_NIBBLE  = 50,
  parameter int P_T_CMD     = 2000,
  parameter int P_T_CLEAR   = 82000,
  parameter int P_T_POWERON = 750000,
  parameter int P_T_INIT1   = 205000,
  parameter int P_T_INIT2   = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam int c_cnt_w = 24;

  localparam logic [2:0] c_st_poweron = 3'd0;
  localparam logic [2:0] c_st_setup   = 3'd1;
  localparam logic [2:0] c_st_pulse   = 3'd2;
  localparam logic [2:0] c_st_hold    = 3'd3;
  localparam logic [2:0] c_st_gap     = 3'd4;
  localparam logic [2:0] c_st_idle    = 3'd5;

  localparam logic [3:0] c_last_init = 4'd11;

  logic [2:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [3:0]         r_seq;
  logic               r_init_done;
  logic               r_lower;
  logic               r_rs;
  logic [7:0]         r_byte;
  logic               r_lcd_rs;
  logic [3:0]         r_lcd_data;
  logic [c_cnt_w-1:0] w_gap;

  // Init stream: four single wake-up nibbles, then 0x28, 0x06, 0x0C, 0x01 as nibble pairs.
  function automatic logic [3:0] init_nibble(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: init_nibble = 4'h3;
      4'd3, 4'd4:       init_nibble = 4'h2;
      4'd5:             init_nibble = 4'h8;
      4'd7:             init_nibble = 4'h6;
      4'd9:             init_nibble = 4'hC;
      4'd11:            init_nibble = 4'h1;
      default:          init_nibble = 4'h0;
    endcase
  endfunction

  function automatic logic [c_cnt_w-1:0] init_gap(input logic [3:0] idx);
    case (idx)
      4'd0:       init_gap = c_cnt_w'(P_T_INIT1 - 1);
      4'd1:       init_gap = c_cnt_w'(P_T_INIT2 - 1);
      4'd2, 4'd3: init_gap = c_cnt_w'(P_T_CMD - 1);
      4'd11:      init_gap = c_cnt_w'(P_T_CLEAR - 1);
      default:    init_gap = idx[0] ? c_cnt_w'(P_T_CMD - 1) : c_cnt_w'(P_T_NIBBLE - 1);
    endcase
  endfunction

  always_comb begin
    w_gap = c_cnt_w'(P_T_CMD - 1);
    if (!r_init_done)
      w_gap = init_gap(r_seq);
    else if (!r_lower)
      w_gap = c_cnt_w'(P_T_NIBBLE - 1);
    else if (!r_rs && (r_byte == 8'h01 || r_byte == 8'h02))
      w_gap = c_cnt_w'(P_T_CLEAR - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_poweron;
      r_cnt       <= c_cnt_w'(P_T_POWERON - 1);
      r_seq       <= 4'd0;
      r_init_done <= 1'b0;
      r_lower     <= 1'b0;
      r_rs        <= 1'b0;
      r_byte      <= 8'h00;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 4'h0;
    end else if (r_state != c_st_idle && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else begin
      case (r_state)
        c_st_poweron: begin
          r_state    <= c_st_setup;
          r_cnt      <= c_cnt_w'(P_T_SETUP - 1);
          r_lcd_data <= init_nibble(4'd0);
        end
        c_st_idle: begin
          if (iValid) begin
            r_state    <= c_st_setup;
            r_cnt      <= c_cnt_w'(P_T_SETUP - 1);
            r_rs       <= iRS;
            r_byte     <= iData;
            r_lower    <= 1'b0;
            r_lcd_rs   <= iRS;
            r_lcd_data <= iData[7:4];
          end
        end
        c_st_setup: begin
          r_state <= c_st_pulse;
          r_cnt   <= c_cnt_w'(P_T_PULSE - 1);
        end
        c_st_pulse: begin
          r_state <= c_st_hold;
          r_cnt   <= c_cnt_w'(P_T_HOLD - 1);
        end
        c_st_hold: begin
          r_state <= c_st_gap;
          r_cnt   <= w_gap;
        end
        c_st_gap: begin
          if (!r_init_done) begin
            if (r_seq == c_last_init) begin
              r_init_done <= 1'b1;
              r_state     <= c_st_idle;
            end else begin
              r_seq      <= r_seq + 4'd1;
              r_lcd_data <= init_nibble(r_seq + 4'd1);
              r_state    <= c_st_setup;
              r_cnt      <= c_cnt_w'(P_T_SETUP - 1);
            end
          end else if (!r_lower) begin
            r_lower    <= 1'b1;
            r_lcd_data <= r_byte[3:0];
            r_state    <= c_st_setup;
            r_cnt      <= c_cnt_w'(P_T_SETUP - 1);
          end else begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_poweron;
          r_cnt   <= c_cnt_w'(P_T_POWERON - 1);
        end
      endcase
    end
  end

  assign oReady    = (r_state == c_st_idle);
  assign oInitDone = r_init_done;
  assign oLCD_E    = (r_state == c_st_pulse);
  assign oLCD_RS   = r_lcd_rs;
  assign oLCD_RW   = 1'b0;
  assign oLCD_Data = r_lcd_data;

endmodule
`default_nettype wire

// File: doc/lcd_write_controller.md
# lcd_write_controller

Downstream consumer of the instruction stream's `LCD` opcode. The CPU decodes `LCD` instructions fetched from program ROM and hands this block one byte at a time, with a register-select flag. The block runs the HD44780 power-on initialisation once after reset. It then serialises each accepted byte as two 4-bit nibbles onto the character-LCD pins, with enable-pulse and inter-command delays counted in clock cycles.

## Interface
Parameters (all counts in clock cycles; defaults are for 50 MHz):
- P_T_SETUP, 2, RS/data setup before E rises (≥40 ns)
- P_T_PULSE, 12, E high width (≥230 ns)
- P_T_HOLD, 1, RS/data hold after E falls
- P_T_NIBBLE, 50, gap between upper and lower nibble (1 µs)
- P_T_CMD, 2000, gap after a full byte (40 µs)
- P_T_CLEAR, 82000, gap after clear/home command (1.64 ms)
- P_T_POWERON, 750000, wait after reset before the first init nibble (15 ms)
- P_T_INIT1, 205000, wait after the first init nibble (4.1 ms)
- P_T_INIT2, 5000, wait after the second init nibble (100 µs)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low; low forces every register to its reset value
- iValid  in  1  byte request from the CPU `LCD` execute stage
- iRS  in  1  0 = command, 1 = character data
- iData  in  8  byte to write
- oReady  out  1  high only in IDLE; a transfer is accepted when iValid & oReady are both high
- oInitDone  out  1  high once the init sequence completes; sticky until reset
- oLCD_E  out  1  LCD enable strobe
- oLCD_RS  out  1  LCD register select
- oLCD_RW  out  1  tied 0 (write only)
- oLCD_Data  out  4  LCD DB7..DB4

## Operation
- Reset values: oReady=0, oInitDone=0, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=0.
- One down-counter (≥20 bits) times every phase. A phase lasts exactly N cycles when its parameter is N.
- States: POWERON → INIT_NIB → CONFIG → IDLE → (SETUP → PULSE → HOLD → GAP) per nibble → IDLE.
- POWERON: wait P_T_POWERON, then go to INIT_NIB.
- INIT_NIB: send single nibbles with RS=0 in this order:
  - 0x3, then wait P_T_INIT1
  - 0x3, then wait P_T_INIT2
  - 0x3, then wait P_T_CMD
  - 0x2, then wait P_T_CMD
- CONFIG: send four command bytes, each as a full two-nibble write:
  - 0x28 (function set)
  - 0x06 (entry mode)
  - 0x0C (display on)
  - 0x01 (clear)
- After the final CONFIG gap, set oInitDone=1 and enter IDLE.
- IDLE: on iValid&oReady, latch iRS/iData and drop oReady the next cycle.
- Each byte is sent upper nibble first. Each nibble runs SETUP(P_T_SETUP), PULSE(P_T_PULSE, E=1), HOLD(P_T_HOLD), GAP.
- GAP length:
  - after the upper nibble: P_T_NIBBLE
  - after the lower nibble with RS=0 and byte 0x01 or 0x02: P_T_CLEAR
  - after any other lower nibble: P_T_CMD
- oLCD_RS and oLCD_Data are stable from the start of SETUP to the end of HOLD. They keep their values during GAP and IDLE.
- iValid while oReady=0 is ignored. No queueing; the CPU stalls until oReady.
- Reset asserted mid-transfer: E drops asynchronously and the full init sequence restarts.

## Timing
- Acceptance edge k: oReady=0 at k+1; SETUP occupies k+1..k+P_T_SETUP.
- E rises at cycle k+1+P_T_SETUP and stays high for exactly P_T_PULSE cycles.
- One byte takes 2·(P_T_SETUP+P_T_PULSE+P_T_HOLD) + P_T_NIBBLE + gap cycles from acceptance until oReady returns high.
- Back-to-back: iValid held high is accepted again on the first IDLE cycle.
- Exactly 2 E pulses per byte. Init produces 4 + 8 = 12 E pulses before oInitDone.

## Test plan
(Set all delay parameters to 1–4 to shorten simulation.)
- Reset release, no requests → 12 E pulses with nibbles 3,3,3,2,2,8,0,6,0,C,0,1 and RS=0; then oInitDone=1 and oReady=1.
- After init, iRS=1, iData=0x48 ('H') → nibbles 4 then 8 with RS=1; E high exactly P_T_PULSE per pulse; oReady returns after P_T_CMD gap.
- iRS=0, iData=0x01 → gap after the lower nibble equals P_T_CLEAR; 0x02 behaves the same; 0x03 uses P_T_CMD.
- iValid held high with 'H' then 'O' (0x4F) back-to-back → accepted on consecutive IDLE entries; 4 pulses; no lost or duplicated byte.
- iValid pulsed while oReady=0 → ignored; no extra E pulse.
- Reset asserted during PULSE → oLCD_E=0 immediately, oInitDone=0; after release the full init sequence repeats.
